aes_ctr_ctrl: RTL and testbench

CTR-mode sequencer for the AES encipher round block. It generates counter blocks, issues one encipher operation per block over the encipher next/ready handshake, and XORs each returned keystream block with a streamed input data block. Output is a valid/ready stream. It sits between the core's block interface and the encipher datapath. Key expansion and key length are configured outside this block.

---
 rtl/aes_ctr_ctrl.sv | 118 +++++++++++
 tb/tb_aes_ctr_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_ctrl.sv
// CTR-mode sequencer: issues one encipher operation per counter block and XORs
// the returned keystream with the streamed input data.
module aes_ctr_ctrl #(
    parameter int unsigned CTR_WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] ctr_init,
    input  logic [15:0]  num_blocks,
    output logic         busy,
    output logic         done,
    output logic [15:0]  blocks_done,
    output logic         enc_next,
    input  logic         enc_ready,
    output logic [127:0] enc_block,
    input  logic [127:0] enc_result,
    input  logic [127:0] data_in,
    input  logic         data_in_valid,
    output logic         data_in_ready,
    output logic [127:0] data_out,
    output logic         data_out_valid,
    input  logic         data_out_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_XOR, S_OUT, S_FINISH
    } state_e;

    // Only the low CTR_WIDTH bits of the counter block take part in the increment.
    localparam logic [127:0] CTR_MASK =
        (CTR_WIDTH >= 128) ? '1 : ((128'd1 << CTR_WIDTH) - 128'd1);

    state_e        state_q, state_d;
    logic [127:0]  ctr_q, ctr_d;
    logic [127:0]  keystream_q, keystream_d;
    logic [127:0]  data_out_q, data_out_d;
    logic [15:0]   remaining_q, remaining_d;
    logic [15:0]   blocks_done_q, blocks_done_d;
    logic [127:0]  ctr_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (start) state_d = (num_blocks == '0) ? S_FINISH : S_ISSUE;
            S_ISSUE:     if (enc_ready) state_d = S_WAIT_ACK;
            S_WAIT_ACK:  if (!enc_ready) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (enc_ready) state_d = S_XOR;
            S_XOR:       if (data_in_valid) state_d = S_OUT;
            S_OUT:       if (data_out_ready) state_d = (remaining_q == 16'd1) ? S_FINISH : S_ISSUE;
            S_FINISH:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    assign ctr_inc = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);

    always_comb begin
        ctr_d         = ctr_q;
        keystream_d   = keystream_q;
        data_out_d    = data_out_q;
        remaining_d   = remaining_q;
        blocks_done_d = blocks_done_q;
        if (state_q == S_IDLE && start) begin
            ctr_d         = ctr_init;
            remaining_d   = num_blocks;
            blocks_done_d = '0;
        end
        if (state_q == S_WAIT_DONE && enc_ready) begin
            keystream_d = enc_result;
        end
        if (state_q == S_XOR && data_in_valid) begin
            data_out_d = data_in ^ keystream_q;
        end
        if (state_q == S_OUT && data_out_ready) begin
            ctr_d         = ctr_inc;
            remaining_d   = remaining_q - 16'd1;
            blocks_done_d = blocks_done_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_q         <= '0;
            keystream_q   <= '0;
            data_out_q    <= '0;
            remaining_q   <= '0;
            blocks_done_q <= '0;
        end else begin
            ctr_q         <= ctr_d;
            keystream_q   <= keystream_d;
            data_out_q    <= data_out_d;
            remaining_q   <= remaining_d;
            blocks_done_q <= blocks_done_d;
        end
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_FINISH);
        enc_next       = (state_q == S_ISSUE) && enc_ready;
        data_in_ready  = (state_q == S_XOR);
        data_out_valid = (state_q == S_OUT);
    end

    assign enc_block   = ctr_q;
    assign data_out    = data_out_q;
    assign blocks_done = blocks_done_q;

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// Scoreboard bench for aes_ctr_ctrl: expected data_out is derived from the counter
// arithmetic of each job and checked by an independent output monitor.
module tb_aes_ctr_ctrl;

    localparam logic [127:0] KS_PAT = {16{8'hA5}};

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] ctr_init;
    logic [15:0]  num_blocks;
    logic         busy;
    logic         done;
    logic [15:0]  blocks_done;
    logic         enc_next;
    logic         enc_ready;
    logic [127:0] enc_block;
    logic [127:0] enc_result;
    logic [127:0] data_in;
    logic         data_in_valid;
    logic         data_in_ready;
    logic [127:0] data_out;
    logic         data_out_valid;
    logic         data_out_ready;

    aes_ctr_ctrl #(.CTR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ctr_init(ctr_init),
        .num_blocks(num_blocks), .busy(busy), .done(done), .blocks_done(blocks_done),
        .enc_next(enc_next), .enc_ready(enc_ready), .enc_block(enc_block),
        .enc_result(enc_result), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .data_out(data_out),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned  pass_cnt = 0;
    int unsigned  total_cnt = 0;
    logic [127:0] sbq[$];
    logic [127:0] job_ctr = '0;
    int unsigned  job_idx = 0;
    int unsigned  enc_cnt = 0;
    int unsigned  out_cnt = 0;
    int unsigned  done_cnt = 0;
    int unsigned  dir_cnt = 0;
    int unsigned  enc_lat = 4;
    int unsigned  abort_gen = 0;
    bit           bp = 1'b1;
    bit           zero_data = 1'b0;
    logic [127:0] last_out = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    // Reference counter: block i of a job is ctr_init with i added modulo 2^32 in the low word.
    function automatic logic [127:0] ctr_at(input logic [127:0] c, input int unsigned i);
        logic [31:0] lo;
        lo = c[31:0] + i;
        return {c[127:32], lo};
    endfunction

    // Encipher model: ready drops after next, result = block ^ A5.. after enc_lat cycles.
    initial begin
        logic [127:0] blk;
        int unsigned  g, lat;
        enc_ready  = 1'b1;
        enc_result = '0;
        forever begin
            @(negedge clk);
            if (enc_next === 1'b1 && !reset) begin
                blk = enc_block;
                g   = abort_gen;
                lat = enc_lat;
                chk("enc_block", blk, ctr_at(job_ctr, enc_cnt));
                enc_cnt++;
                @(posedge clk); #1 enc_ready = 1'b0;
                for (int c = 1; c < int'(lat); c++) begin
                    @(negedge clk);
                    if (g == abort_gen) chk("enc_block_stable", enc_block, blk);
                    @(posedge clk);
                end
                #1;
                enc_ready  = 1'b1;
                enc_result = blk ^ KS_PAT;
            end
        end
    end

    // Input stream driver: pushes the expected output for every accepted data block.
    initial begin
        data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            data_in_valid  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            data_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            data_in        = zero_data ? '0 : {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            if (!reset && data_in_valid && data_in_ready) begin
                sbq.push_back(data_in ^ ctr_at(job_ctr, job_idx) ^ KS_PAT);
                job_idx++;
            end
        end
    end

    // Output monitor.
    initial begin
        bit           pending;
        logic [127:0] held;
        pending = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (data_in_ready === 1'b1) dir_cnt++;
            if (pending && !reset) chk("out_stable", {127'd0, data_out_valid} << 127 | (data_out & {1'b0, {127{1'b1}}}),
                                        {1'b1, held[126:0]});
            pending = 1'b0;
            if (data_out_valid === 1'b1 && !reset) begin
                if (data_out_ready) begin
                    if (sbq.size() == 0) begin
                        total_cnt++;
                        $display("FAIL data_out: got %h with no expected entry", data_out);
                    end else begin
                        chk("data_out", data_out, sbq.pop_front());
                    end
                    last_out = data_out;
                    out_cnt++;
                end else begin
                    pending = 1'b1;
                    held    = data_out;
                end
            end
        end
    end

    task automatic pulse_start(input logic [127:0] c, input logic [15:0] n);
        @(posedge clk); #1;
        ctr_init = c; num_blocks = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input logic [127:0] c, input int unsigned n, input int unsigned lat,
                           input bit b, input bit z);
        int unsigned budget, waited;
        bit          seen;
        job_ctr = c; job_idx = 0; enc_cnt = 0; out_cnt = 0; done_cnt = 0; dir_cnt = 0;
        enc_lat = lat; bp = b; zero_data = z;
        sbq.delete();
        pulse_start(c, 16'(n));
        budget = 100 + n * (lat + 4) * 12;
        seen   = 1'b0;
        waited = 0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
            waited++;
        end
        chk("done_seen", {127'd0, seen}, 128'd1);
        if (n == 0) chk("zero_len_done_latency", 128'(waited), 128'd0);
        chk("blocks_done", 128'(blocks_done), 128'(n));
        chk("busy_at_done", {127'd0, busy}, 128'd1);
        @(negedge clk);
        chk("busy_after_done", {127'd0, busy}, 128'd0);
        chk("enc_next_count", 128'(enc_cnt), 128'(n));
        chk("out_handshakes", 128'(out_cnt), 128'(n));
        chk("done_pulses", 128'(done_cnt), 128'd1);
        chk("sb_empty", 128'(sbq.size()), 128'd0);
        if (n == 0) chk("zero_len_no_ready", 128'(dir_cnt), 128'd0);
        zero_data = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; ctr_init = '0; num_blocks = '0;

        // Reset with random inputs, including start.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom_range(0, 1)); ctr_init = {4{$urandom()}};
            num_blocks = 16'($urandom());
        end
        @(negedge clk);
        chk("rst_outputs", {123'd0, busy, done, enc_next, data_in_ready, data_out_valid}, '0);
        chk("rst_enc_block", enc_block, '0);
        chk("rst_data_out", data_out, '0);
        chk("rst_blocks_done", 128'(blocks_done), '0);
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", {127'd0, busy}, '0);
        chk("rst_no_enc_next", 128'(enc_cnt), '0);

        run_job(128'h1, 1, 12, 1'b0, 1'b1);
        chk("single_block_value", last_out, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A4);

        run_job(128'h11223344_55667788_99AABBCC_FFFFFFFE, 3, 3, 1'b0, 1'b0);
        chk("wrap_final_ctr", enc_block, 128'h11223344_55667788_99AABBCC_00000001);

        run_job(128'hDEADBEEF, 0, 4, 1'b0, 1'b0);

        run_job({4{$urandom()}}, 4, 5, 1'b1, 1'b0);

        // Abort: a second start mid-job is ignored, then reset lands in WAIT_DONE.
        job_ctr = 128'hCAFE0000_00000000_00000000_00000010;
        job_idx = 0; enc_cnt = 0; enc_lat = 12; bp = 1'b0; sbq.delete();
        pulse_start(job_ctr, 16'd3);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (enc_cnt != 0) break;
        end
        chk("abort_first_issue", 128'(enc_cnt), 128'd1);
        pulse_start(128'h12345678_9ABCDEF0_0F0F0F0F_00000000, 16'd7);
        chk("restart_ignored_ctr", enc_block, job_ctr);
        @(posedge clk); #1;
        reset = 1'b1; abort_gen++;
        @(posedge clk); #1;
        reset = 1'b0; sbq.delete();
        @(negedge clk);
        chk("abort_idle", {126'd0, busy, data_in_ready}, '0);
        chk("abort_blocks_done", 128'(blocks_done), '0);
        chk("abort_enc_block", enc_block, '0);
        run_job(128'h0A0B0C0D_00000000_00000000_FFFFFFFF, 2, 6, 1'b1, 1'b0);

        for (int j = 0; j < 4; j++) begin
            run_job({$urandom(), $urandom(), $urandom(), 32'hFFFFFFF0 | 32'($urandom_range(0, 15))},
                    $urandom_range(1, 5), $urandom_range(2, 8), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
